// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the multicycle 16-bit CPU blocks
// (control unit, datapath, memory responder).
//   CPU_WORD_SIZE / CPU_ADDR_SIZE : default data / word-address widths
//   mem_state_t                   : memory responder FSM states
package cpu_pkg;

    localparam int CPU_WORD_SIZE = 16;
    localparam int CPU_ADDR_SIZE = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_responder_mem_array.sv
// mem_array: single-port MEM_DEPTH x WORD_SIZE storage.
// The write is synchronous. The read is registered, and the read register
// holds its value until the next rd_en or rd_clr. Storage is not reset.
// Ports:
//   clk    in  clock
//   wr_en  in  write idx with wdata on this edge
//   rd_en  in  load rdata from idx on this edge
//   rd_clr in  clear rdata to 0 (takes priority over rd_en)
//   idx    in  word index
//   wdata  in  write data
//   rdata  out registered read data
module mem_array #(
    parameter int WORD_SIZE = 16,
    parameter int MEM_DEPTH = 256,
    localparam int IDX_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic                 rd_en,
    input  logic                 rd_clr,
    input  logic [IDX_W-1:0]     idx,
    input  logic [WORD_SIZE-1:0] wdata,
    output logic [WORD_SIZE-1:0] rdata
);

    logic [WORD_SIZE-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[idx] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_clr) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: word-addressed memory with a req/ready handshake and
// WAIT_STATES extra cycles per access. It serves the CPU control unit for
// instruction fetch and data load/store.
// Optional feature: define MEM_BOUNDS_CHECK_EN to flag and suppress accesses
// with addr >= MEM_DEPTH. When it is undefined, addr wraps modulo MEM_DEPTH
// and fault is tied 0.
// Ports:
//   clk      in  clock
//   rst      in  synchronous active-high reset
//   req      in  access request, sampled in IDLE only
//   we       in  1 = write, 0 = read, sampled with req
//   addr     in  word address, sampled with req
//   data_in  in  write data, sampled with req
//   data_out out read data, held until the next read completes
//   ready    out one-cycle completion pulse
//   busy     out high from the cycle after acceptance through ready
//   fault    out out-of-range flag during the ready cycle
module mem_responder
    import cpu_pkg::*;
#(
    parameter int WORD_SIZE   = CPU_WORD_SIZE,
    parameter int ADDR_SIZE   = CPU_ADDR_SIZE,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    input  logic                 we,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [WORD_SIZE-1:0] data_in,
    output logic [WORD_SIZE-1:0] data_out,
    output logic                 ready,
    output logic                 busy,
    output logic                 fault
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES);

    mem_state_t state, state_next;
    logic [3:0]           cnt;
    logic                 we_q;
    logic [ADDR_SIZE-1:0] addr_q;
    logic [WORD_SIZE-1:0] data_q;

    logic                 acc_we;
    logic [ADDR_SIZE-1:0] acc_addr;
    logic [WORD_SIZE-1:0] acc_data;
    logic                 commit;
    logic                 oob;
    logic                 wr_en;
    logic                 rd_en;
    logic                 rd_clr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (req) state_next = (WAIT_STATES > 0) ? WAIT : RESP;
            WAIT: if (cnt == 4'd1) state_next = RESP;
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == IDLE && req) begin
            cnt <= CNT_INIT;
        end else if (state == WAIT) begin
            cnt <= cnt - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && req) begin
            we_q   <= we;
            addr_q <= addr;
            data_q <= data_in;
        end
    end

    // With zero wait states the access completes on the acceptance edge,
    // before the latch holds anything, so the live inputs are used in IDLE.
    always_comb begin
        acc_we   = we_q;
        acc_addr = addr_q;
        acc_data = data_q;
        if (state == IDLE) begin
            acc_we   = we;
            acc_addr = addr;
            acc_data = data_in;
        end
    end

    // The access takes effect on the edge that enters RESP, unless reset wins.
    assign commit = !rst && (state != RESP) && (state_next == RESP);

`ifdef MEM_BOUNDS_CHECK_EN
    logic fault_q;

    assign oob = (32'(acc_addr) >= 32'(MEM_DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else if (commit) begin
            fault_q <= oob;
        end
    end

    assign fault = fault_q && (state == RESP);
`else
    assign oob   = 1'b0;
    assign fault = 1'b0;
`endif

    assign wr_en  = commit && acc_we && !oob;
    assign rd_en  = commit && !acc_we;
    assign rd_clr = rst || (commit && !acc_we && oob);

    mem_array #(
        .WORD_SIZE (WORD_SIZE),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_mem (
        .clk    (clk),
        .wr_en  (wr_en),
        .rd_en  (rd_en),
        .rd_clr (rd_clr),
        .idx    (acc_addr[IDX_W-1:0]),
        .wdata  (acc_data),
        .rdata  (data_out)
    );

    assign ready = (state == RESP);
    assign busy  = (state != IDLE);

endmodule
